// File: rtl/ahbl_aphase_buffer.sv
// Per-master one-entry AHB-Lite address-phase buffer ahead of the slave-side bus mux.
// Latency: a granted, non-pending master passes through in the same cycle; a buffered phase adds at least 1 cycle.
// Backpressure: an ungranted master's phase is captured and m_HREADY drops until the buffered phase issues.
module ahbl_aphase_buffer #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                                  HCLK,
  input  logic                                  HRESET,
  input  logic [NUM_MASTERS-1:0][1:0]           m_HTRANS,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_HADDR,
  input  logic [NUM_MASTERS-1:0]                m_HWRITE,
  input  logic [NUM_MASTERS-1:0][2:0]           m_HSIZE,
  input  logic [NUM_MASTERS-1:0][2:0]           m_HBURST,
  input  logic [NUM_MASTERS-1:0][3:0]           m_HPROT,
  output logic [NUM_MASTERS-1:0]                m_HREADY,
  output logic [NUM_MASTERS-1:0]                pending,
  input  logic [NUM_MASTERS-1:0]                ARB_GRANT,
  input  logic                                  s_HREADY,
  output logic [1:0]                            s_HTRANS,
  output logic [ADDR_WIDTH-1:0]                 s_HADDR,
  output logic                                  s_HWRITE,
  output logic [2:0]                            s_HSIZE,
  output logic [2:0]                            s_HBURST,
  output logic [3:0]                            s_HPROT,
  output logic [MW-1:0]                         s_MASTER
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                 state_q [NUM_MASTERS];
  state_t                 state_d [NUM_MASTERS];
  logic [1:0]             hold_trans [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0]  hold_addr  [NUM_MASTERS];
  logic                   hold_write [NUM_MASTERS];
  logic [2:0]             hold_size  [NUM_MASTERS];
  logic [2:0]             hold_burst [NUM_MASTERS];
  logic [3:0]             hold_prot  [NUM_MASTERS];

  logic                   grant_ok;
  logic [MW-1:0]          gsel;
  logic [NUM_MASTERS-1:0] accept;
  logic [NUM_MASTERS-1:0] issue;
  logic [NUM_MASTERS-1:0] capture;

  // Decode the arbiter grant; anything other than exactly one bit selects nobody.
  always_comb begin
    grant_ok = $onehot(ARB_GRANT) && !HRESET;
    gsel     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ARB_GRANT[i]) gsel = MW'(i);
    end
  end

  // Per-channel ready back to the master, plus the accept and issue qualifiers.
  always_comb begin
    m_HREADY = '0;
    pending  = '0;
    accept   = '0;
    issue    = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      case (state_q[i])
        ST_IDLE: m_HREADY[i] = 1'b1;
        ST_PEND: m_HREADY[i] = 1'b0;
        default: m_HREADY[i] = s_HREADY;
      endcase
      pending[i] = (state_q[i] == ST_PEND);
      accept[i]  = m_HTRANS[i][1] && m_HREADY[i];
      issue[i]   = grant_ok && ARB_GRANT[i] && s_HREADY;
    end
  end

  // Next-state logic; a capture happens whenever an accepted phase cannot issue.
  always_comb begin
    capture = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (accept[i] && issue[i]) begin
            state_d[i] = ST_DATA;
          end else if (accept[i]) begin
            state_d[i] = ST_PEND;
            capture[i] = 1'b1;
          end
        end
        ST_PEND: begin
          // Master inputs are ignored here; only the grant moves the buffer on.
          if (issue[i]) state_d[i] = ST_DATA;
        end
        ST_DATA: begin
          // A stalled data phase freezes the channel; accept is already false then.
          if (s_HREADY) begin
            if (accept[i] && issue[i]) begin
              state_d[i] = ST_DATA;
            end else if (accept[i]) begin
              state_d[i] = ST_PEND;
              capture[i] = 1'b1;
            end else begin
              state_d[i] = ST_IDLE;
            end
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  // Channel state and address-phase buffers; reset discards any buffered transfer.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        state_q[i]    <= ST_IDLE;
        hold_trans[i] <= '0;
        hold_addr[i]  <= '0;
        hold_write[i] <= 1'b0;
        hold_size[i]  <= '0;
        hold_burst[i] <= '0;
        hold_prot[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        state_q[i] <= state_d[i];
        if (capture[i]) begin
          hold_trans[i] <= m_HTRANS[i];
          hold_addr[i]  <= m_HADDR[i];
          hold_write[i] <= m_HWRITE[i];
          hold_size[i]  <= m_HSIZE[i];
          hold_burst[i] <= m_HBURST[i];
          hold_prot[i]  <= m_HPROT[i];
        end
      end
    end
  end

  // Slave-side mux: buffered phase for a pending granted master, live phase otherwise.
  always_comb begin
    s_HTRANS = 2'b00;
    s_HADDR  = '0;
    s_HWRITE = 1'b0;
    s_HSIZE  = '0;
    s_HBURST = '0;
    s_HPROT  = '0;
    s_MASTER = '0;
    if (grant_ok) begin
      s_MASTER = gsel;
      if (state_q[gsel] == ST_PEND) begin
        s_HTRANS = hold_trans[gsel];
        s_HADDR  = hold_addr[gsel];
        s_HWRITE = hold_write[gsel];
        s_HSIZE  = hold_size[gsel];
        s_HBURST = hold_burst[gsel];
        s_HPROT  = hold_prot[gsel];
      end else begin
        s_HTRANS = m_HTRANS[gsel];
        s_HADDR  = m_HADDR[gsel];
        s_HWRITE = m_HWRITE[gsel];
        s_HSIZE  = m_HSIZE[gsel];
        s_HBURST = m_HBURST[gsel];
        s_HPROT  = m_HPROT[gsel];
      end
    end
  end

endmodule

// File: tb/tb_ahbl_aphase_buffer.sv
// Directed bench for ahbl_aphase_buffer with two masters.
// Inputs change 1 time unit after the rising edge; outputs are compared a unit later.
// Each scenario task carries its own hand-derived expectations.
module tb_ahbl_aphase_buffer;

  logic             HCLK;
  logic             HRESET;
  logic [1:0][1:0]  m_HTRANS;
  logic [1:0][31:0] m_HADDR;
  logic [1:0]       m_HWRITE;
  logic [1:0][2:0]  m_HSIZE;
  logic [1:0][2:0]  m_HBURST;
  logic [1:0][3:0]  m_HPROT;
  logic [1:0]       m_HREADY;
  logic [1:0]       pending;
  logic [1:0]       ARB_GRANT;
  logic             s_HREADY;
  logic [1:0]       s_HTRANS;
  logic [31:0]      s_HADDR;
  logic             s_HWRITE;
  logic [2:0]       s_HSIZE;
  logic [2:0]       s_HBURST;
  logic [3:0]       s_HPROT;
  logic [0:0]       s_MASTER;

  int tests;
  int fails;

  ahbl_aphase_buffer #(.NUM_MASTERS(2), .ADDR_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .m_HTRANS(m_HTRANS), .m_HADDR(m_HADDR), .m_HWRITE(m_HWRITE),
    .m_HSIZE(m_HSIZE), .m_HBURST(m_HBURST), .m_HPROT(m_HPROT),
    .m_HREADY(m_HREADY), .pending(pending),
    .ARB_GRANT(ARB_GRANT), .s_HREADY(s_HREADY),
    .s_HTRANS(s_HTRANS), .s_HADDR(s_HADDR), .s_HWRITE(s_HWRITE),
    .s_HSIZE(s_HSIZE), .s_HBURST(s_HBURST), .s_HPROT(s_HPROT),
    .s_MASTER(s_MASTER)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (pending !== 2'b00) begin fails++; $display("FAIL reset_pending got %b want 00", pending); end
    tests++; if (m_HREADY !== 2'b11) begin fails++; $display("FAIL reset_hready got %b want 11", m_HREADY); end
    tests++; if (s_HTRANS !== 2'b00) begin fails++; $display("FAIL reset_htrans got %b want 00", s_HTRANS); end
    tests++; if (s_HADDR !== 32'h0) begin fails++; $display("FAIL reset_haddr got %h want 0", s_HADDR); end
    tests++; if (s_MASTER !== 1'b0) begin fails++; $display("FAIL reset_master got %0d want 0", s_MASTER); end
    tick(); tick();
    HRESET = 1'b0;
  endtask

  task automatic test_reset_mid_pend();
    ARB_GRANT = 2'b10; s_HREADY = 1'b1;
    m_HTRANS[0] = 2'b10; m_HADDR[0] = 32'h1000;
    tick();
    m_HTRANS[0] = 2'b00; m_HADDR[0] = 32'h0;
    #1;
    tests++; if (pending !== 2'b01) begin fails++; $display("FAIL rmp_pending got %b want 01", pending); end
    tests++; if (m_HREADY !== 2'b10) begin fails++; $display("FAIL rmp_hready got %b want 10", m_HREADY); end
    #1 HRESET = 1'b1;
    #1;
    tests++; if (pending !== 2'b00) begin fails++; $display("FAIL rmp_rst_pending got %b want 00", pending); end
    tests++; if (m_HREADY !== 2'b11) begin fails++; $display("FAIL rmp_rst_hready got %b want 11", m_HREADY); end
    tests++; if (s_HTRANS !== 2'b00) begin fails++; $display("FAIL rmp_rst_htrans got %b want 00", s_HTRANS); end
    #2 HRESET = 1'b0;
    ARB_GRANT = 2'b01;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++; if (s_HTRANS !== 2'b00 || s_HADDR !== 32'h0) begin fails++; $display("FAIL rmp_no_replay got %b/%h want 00/0", s_HTRANS, s_HADDR); end
      tests++; if (pending !== 2'b00) begin fails++; $display("FAIL rmp_after_pending got %b want 00", pending); end
    end
  endtask

  task automatic test_passthrough();
    ARB_GRANT = 2'b01; s_HREADY = 1'b1;
    m_HTRANS[0] = 2'b10; m_HADDR[0] = 32'h2000; m_HSIZE[0] = 3'd2;
    #1;
    tests++; if (s_HADDR !== 32'h2000) begin fails++; $display("FAIL pt_haddr got %h want 2000", s_HADDR); end
    tests++; if (s_HTRANS !== 2'b10) begin fails++; $display("FAIL pt_htrans got %b want 10", s_HTRANS); end
    tests++; if (s_MASTER !== 1'b0) begin fails++; $display("FAIL pt_master got %0d want 0", s_MASTER); end
    tick();
    m_HTRANS[0] = 2'b00; s_HREADY = 1'b0;
    #1;
    tests++; if (m_HREADY[0] !== 1'b0) begin fails++; $display("FAIL pt_hready_low got %b want 0", m_HREADY[0]); end
    tests++; if (pending[0] !== 1'b0) begin fails++; $display("FAIL pt_pending got %b want 0", pending[0]); end
    s_HREADY = 1'b1;
    #1;
    tests++; if (m_HREADY[0] !== 1'b1) begin fails++; $display("FAIL pt_hready_high got %b want 1", m_HREADY[0]); end
    tick();
  endtask

  task automatic test_capture_replay();
    ARB_GRANT = 2'b01; s_HREADY = 1'b1;
    m_HTRANS[0] = 2'b00;
    m_HTRANS[1] = 2'b10; m_HADDR[1] = 32'h3004; m_HWRITE[1] = 1'b1;
    m_HSIZE[1] = 3'd2; m_HBURST[1] = 3'd0; m_HPROT[1] = 4'd3;
    tick();
    m_HADDR[1] = 32'hDEAD0000; m_HWRITE[1] = 1'b0; m_HSIZE[1] = 3'd0; m_HPROT[1] = 4'd0;
    #1;
    tests++; if (pending !== 2'b10) begin fails++; $display("FAIL cr_pending got %b want 10", pending); end
    tests++; if (m_HREADY[1] !== 1'b0) begin fails++; $display("FAIL cr_hready got %b want 0", m_HREADY[1]); end
    tick(); tick();
    tests++; if (pending[1] !== 1'b1) begin fails++; $display("FAIL cr_hold_pending got %b want 1", pending[1]); end
    ARB_GRANT = 2'b10;
    #1;
    tests++; if (s_HADDR !== 32'h3004) begin fails++; $display("FAIL cr_haddr got %h want 3004", s_HADDR); end
    tests++; if (s_HWRITE !== 1'b1) begin fails++; $display("FAIL cr_hwrite got %b want 1", s_HWRITE); end
    tests++; if (s_HSIZE !== 3'd2) begin fails++; $display("FAIL cr_hsize got %0d want 2", s_HSIZE); end
    tests++; if (s_HPROT !== 4'd3) begin fails++; $display("FAIL cr_hprot got %0d want 3", s_HPROT); end
    tests++; if (s_MASTER !== 1'b1) begin fails++; $display("FAIL cr_master got %0d want 1", s_MASTER); end
    tests++; if (s_HTRANS !== 2'b10) begin fails++; $display("FAIL cr_htrans got %b want 10", s_HTRANS); end
    tick();
    m_HTRANS[1] = 2'b00;
    #1;
    tests++; if (pending[1] !== 1'b0) begin fails++; $display("FAIL cr_data_pending got %b want 0", pending[1]); end
    tests++; if (m_HREADY[1] !== 1'b1) begin fails++; $display("FAIL cr_data_hready got %b want 1", m_HREADY[1]); end
    tick();
  endtask

  task automatic test_slave_wait();
    ARB_GRANT = 2'b01; s_HREADY = 1'b1;
    m_HTRANS[0] = 2'b00;
    m_HTRANS[1] = 2'b10; m_HADDR[1] = 32'h4000;
    tick();
    m_HADDR[1] = 32'h4444;
    ARB_GRANT = 2'b10; s_HREADY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (s_HADDR !== 32'h4000) begin fails++; $display("FAIL sw_haddr[%0d] got %h want 4000", c, s_HADDR); end
      tests++; if (pending[1] !== 1'b1) begin fails++; $display("FAIL sw_pending[%0d] got %b want 1", c, pending[1]); end
      tick();
    end
    s_HREADY = 1'b1;
    #1;
    tests++; if (pending[1] !== 1'b1 || s_HADDR !== 32'h4000) begin fails++; $display("FAIL sw_pre_issue got %b/%h want 1/4000", pending[1], s_HADDR); end
    tick();
    m_HTRANS[1] = 2'b00;
    #1;
    tests++; if (pending[1] !== 1'b0) begin fails++; $display("FAIL sw_issued got %b want 0", pending[1]); end
    tick();
  endtask

  task automatic test_contention();
    int k[2];
    int qm[$];
    int qa[$];
    logic [1:0] adv;
    logic done;
    int j;
    k[0] = 0; k[1] = 0; done = 1'b0; s_HREADY = 1'b1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      ARB_GRANT = (cyc % 2 == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < 2; i++) begin
        if (k[i] < 4) begin
          m_HTRANS[i] = 2'b10;
          m_HADDR[i]  = (i == 0 ? 32'h5000 : 32'h6000) + 32'(4 * k[i]);
        end else begin
          m_HTRANS[i] = 2'b00;
          m_HADDR[i]  = 32'h0;
        end
      end
      #1;
      if (s_HREADY && s_HTRANS[1]) begin
        qm.push_back(int'(s_MASTER));
        qa.push_back(int'(s_HADDR));
      end
      for (int i = 0; i < 2; i++) adv[i] = m_HREADY[i] && (k[i] < 4);
      tick();
      for (int i = 0; i < 2; i++) if (adv[i]) k[i]++;
      if (cyc == 0) begin
        tests++; if (pending !== 2'b10) begin fails++; $display("FAIL ct_simul_pending got %b want 10", pending); end
      end
      if (k[0] == 4 && k[1] == 4 && pending == 2'b00) done = 1'b1;
    end
    tests++; if (!done) begin fails++; $display("FAIL ct_timeout got k0=%0d k1=%0d pend=%b want all issued", k[0], k[1], pending); end
    tests++; if (qa.size() != 8) begin fails++; $display("FAIL ct_count got %0d want 8", qa.size()); end
    for (int m = 0; m < 2; m++) begin
      j = 0;
      for (int e = 0; e < qa.size(); e++) begin
        if (qm[e] == m) begin
          tests++;
          if (qa[e] != (m == 0 ? 32'h5000 : 32'h6000) + 4 * j) begin
            fails++;
            $display("FAIL ct_order m%0d[%0d] got %h want %h", m, j, qa[e], (m == 0 ? 32'h5000 : 32'h6000) + 4 * j);
          end
          j++;
        end
      end
      tests++; if (j != 4) begin fails++; $display("FAIL ct_per_master m%0d got %0d want 4", m, j); end
    end
    m_HTRANS[0] = 2'b00; m_HTRANS[1] = 2'b00;
    tick();
  endtask

  task automatic test_illegal_grant();
    s_HREADY = 1'b1;
    m_HTRANS[1] = 2'b00;
    m_HTRANS[0] = 2'b10; m_HADDR[0] = 32'h7000;
    ARB_GRANT = 2'b11;
    #1;
    tests++; if (s_HTRANS !== 2'b00) begin fails++; $display("FAIL ig11_htrans got %b want 00", s_HTRANS); end
    tests++; if (s_HADDR !== 32'h0) begin fails++; $display("FAIL ig11_haddr got %h want 0", s_HADDR); end
    tests++; if (s_MASTER !== 1'b0) begin fails++; $display("FAIL ig11_master got %0d want 0", s_MASTER); end
    tick();
    tests++; if (pending !== 2'b01) begin fails++; $display("FAIL ig11_pending got %b want 01", pending); end
    ARB_GRANT = 2'b00;
    #1;
    tests++; if (s_HTRANS !== 2'b00) begin fails++; $display("FAIL ig00_htrans got %b want 00", s_HTRANS); end
    tick();
    tests++; if (pending !== 2'b01) begin fails++; $display("FAIL ig00_pending got %b want 01", pending); end
    ARB_GRANT = 2'b01;
    #1;
    tests++; if (s_HADDR !== 32'h7000 || s_HTRANS !== 2'b10) begin fails++; $display("FAIL ig_replay got %h/%b want 7000/10", s_HADDR, s_HTRANS); end
    tick();
    m_HTRANS[0] = 2'b00;
    #1;
    tests++; if (pending !== 2'b00) begin fails++; $display("FAIL ig_done_pending got %b want 00", pending); end
    tick();
  endtask

  initial begin
    tests = 0; fails = 0;
    HRESET = 1'b1; s_HREADY = 1'b1; ARB_GRANT = 2'b00;
    m_HTRANS = '0; m_HADDR = '0; m_HWRITE = '0;
    m_HSIZE = '0; m_HBURST = '0; m_HPROT = '0;
    test_reset();
    test_reset_mid_pend();
    test_passthrough();
    test_capture_replay();
    test_slave_wait();
    test_contention();
    test_illegal_grant();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
